// File: rtl/mem_req_ctrl_pkg.sv
// Shared definitions for the data-memory request controller:
// memType encodings, FSM state enum, timeout default and small decode helpers.
package mem_pkg;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic mt_legal(input logic [2:0] mt);
        return (mt == MT_B) || (mt == MT_H) || (mt == MT_W) ||
               (mt == MT_BU) || (mt == MT_HU);
    endfunction

    function automatic logic mt_aligned(input logic [2:0] mt,
                                        input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        if (mt == MT_H || mt == MT_HU) ok = ~off[0];
        if (mt == MT_W)                ok = (off == 2'b00);
        return ok;
    endfunction

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Data-memory bus between the request controller (master) and memory (slave).
// Ports: dm_req/dm_we/dm_addr/dm_be/dm_wdata toward memory; dm_rdata/dm_ack back.
interface mem_req_ctrl_if;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_rdata, dm_ack
    );

endinterface

// File: rtl/mem_req_ctrl_load_aligner.sv
// Combinational load lane extraction with sign/zero extension.
// Ports: rdata (read word), addr (byte offset), mem_type; result (32-bit value).
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_type,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        unique case (addr)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        unique case (1'b1)
            mem_type == MT_B:  result = {{24{byte_v[7]}}, byte_v};
            mem_type == MT_BU: result = {24'd0, byte_v};
            mem_type == MT_H:  result = {{16{half_v[15]}}, half_v};
            mem_type == MT_HU: result = {16'd0, half_v};
            default:           result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// MEM-stage data-memory request controller: IDLE/REQ/DONE FSM issuing one
// access per instruction, store lane steering, load writeback, misalign and
// bus-timeout exceptions.
// Ports: clk, rst (sync, active-high); ex_* request from EX/MEM; stall;
// dm (memory bus, master); wb_valid/wb_rd/wb_data; exc_misalign, exc_buserr.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_memRead,
    input  logic                  ex_memWrite,
    input  logic [2:0]            ex_memType,
    input  logic [31:0]           ex_addr,
    input  logic [31:0]           ex_wdata,
    input  logic [4:0]            ex_rd,
    output logic                  stall,
    mem_req_ctrl_if.master        dm,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  exc_misalign,
    output logic                  exc_buserr
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [2:0]  mt_q, mt_d;
    logic [1:0]  off_q, off_d;
    logic        is_load_q, is_load_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_mis_q, exc_mis_d;
    logic        exc_bus_q, exc_bus_d;

    logic        one_op;
    logic        legal;
    logic        aligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_result;

    load_aligner u_load_aligner (
        .rdata    (dm.dm_rdata),
        .addr     (off_q),
        .mem_type (mt_q),
        .result   (ld_result)
    );

    // Store lane steering: narrow data is replicated across the word so
    // memory only has to honour the byte enables.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
        unique case (1'b1)
            ex_memType == MT_B: begin
                st_be    = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            ex_memType == MT_H: begin
                st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_wdata;
            end
        endcase
    end

    always_comb begin
        one_op  = ex_memRead ^ ex_memWrite;
        legal   = mt_legal(ex_memType);
        aligned = mt_aligned(ex_memType, ex_addr[1:0]);

        state_d    = state_q;
        cnt_d      = cnt_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        mt_d       = mt_q;
        off_d      = off_q;
        is_load_d  = is_load_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = 32'd0;
        exc_mis_d  = 1'b0;
        exc_bus_d  = 1'b0;
        stall      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ex_valid && one_op && legal) begin
                    if (aligned) begin
                        stall      = 1'b1;
                        state_d    = S_REQ;
                        cnt_d      = 8'd0;
                        dm_req_d   = 1'b1;
                        dm_we_d    = ex_memWrite;
                        dm_addr_d  = {ex_addr[31:2], 2'b00};
                        dm_be_d    = ex_memWrite ? st_be : 4'b1111;
                        dm_wdata_d = ex_memWrite ? st_wdata : 32'd0;
                        mt_d       = ex_memType;
                        off_d      = ex_addr[1:0];
                        is_load_d  = ex_memRead;
                        rd_d       = ex_rd;
                    end else begin
                        exc_mis_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                stall = 1'b1;
                // A late ack in the final counted cycle still wins.
                if (dm.dm_ack || cnt_q == CNT_LAST) begin
                    state_d    = S_DONE;
                    dm_req_d   = 1'b0;
                    dm_we_d    = 1'b0;
                    dm_addr_d  = 32'd0;
                    dm_be_d    = 4'd0;
                    dm_wdata_d = 32'd0;
                    if (dm.dm_ack) begin
                        if (is_load_q) begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = rd_q;
                            wb_data_d  = ld_result;
                        end
                    end else begin
                        exc_bus_d = 1'b1;
                        cnt_d     = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Keep stall low while reset is held so all outputs read zero.
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'd0;
            dm_be_q    <= 4'd0;
            dm_wdata_q <= 32'd0;
            mt_q       <= 3'd0;
            off_q      <= 2'd0;
            is_load_q  <= 1'b0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            exc_mis_q  <= 1'b0;
            exc_bus_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            mt_q       <= mt_d;
            off_q      <= off_d;
            is_load_q  <= is_load_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            exc_mis_q  <= exc_mis_d;
            exc_bus_q  <= exc_bus_d;
        end
    end

    assign dm.dm_req     = dm_req_q;
    assign dm.dm_we      = dm_we_q;
    assign dm.dm_addr    = dm_addr_q;
    assign dm.dm_be      = dm_be_q;
    assign dm.dm_wdata   = dm_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign exc_misalign  = exc_mis_q;
    assign exc_buserr    = exc_bus_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed self-checking bench for mem_req_ctrl (TIMEOUT=4).
// Inputs change 1ns after each rising edge; outputs are checked mid-cycle.
module tb_mem_req_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_memRead;
    logic        ex_memWrite;
    logic [2:0]  ex_memType;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rd;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_misalign;
    logic        exc_buserr;

    int checks;
    int failures;

    mem_req_ctrl_if dm_bus ();

    mem_req_ctrl #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_memRead   (ex_memRead),
        .ex_memWrite  (ex_memWrite),
        .ex_memType   (ex_memType),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd        (ex_rd),
        .stall        (stall),
        .dm           (dm_bus),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .exc_misalign (exc_misalign),
        .exc_buserr   (exc_buserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic w,
                         input logic [2:0] mt, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        ex_valid    = v;
        ex_memRead  = r;
        ex_memWrite = w;
        ex_memType  = mt;
        ex_addr     = a;
        ex_wdata    = wd;
        ex_rd       = rd;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        idle_in();
        dm_bus.dm_rdata = 32'd0;
        dm_bus.dm_ack   = 1'b0;
        tick();
        tick();
        mid();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_bus.dm_req}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_exc", {30'd0, exc_misalign, exc_buserr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_dm_addr", dm_bus.dm_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // LB 0x103, ack in first REQ cycle
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 5'd5);
        mid();
        chk("lb_accept_stall", {31'd0, stall}, 32'd1);
        tick();
        idle_in();
        dm_bus.dm_rdata = 32'h80FF_FF12;
        dm_bus.dm_ack   = 1'b1;
        mid();
        chk("lb_req", {31'd0, dm_bus.dm_req}, 32'd1);
        chk("lb_we", {31'd0, dm_bus.dm_we}, 32'd0);
        chk("lb_be", {28'd0, dm_bus.dm_be}, 32'hF);
        chk("lb_addr", dm_bus.dm_addr, 32'h100);
        chk("lb_req_stall", {31'd0, stall}, 32'd1);
        tick();
        dm_bus.dm_ack = 1'b0;
        mid();
        chk("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_wb_rd", {27'd0, wb_rd}, 32'd5);
        chk("lb_done_stall", {31'd0, stall}, 32'd0);
        chk("lb_done_req", {31'd0, dm_bus.dm_req}, 32'd0);
        tick();
        mid();
        chk("lb_wb_pulse_end", {31'd0, wb_valid}, 32'd0);

        // SH 0x102, ack after one wait cycle
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 5'd0);
        tick();
        idle_in();
        mid();
        chk("sh_req", {31'd0, dm_bus.dm_req}, 32'd1);
        chk("sh_we", {31'd0, dm_bus.dm_we}, 32'd1);
        chk("sh_be", {28'd0, dm_bus.dm_be}, 32'hC);
        chk("sh_wdata", dm_bus.dm_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dm_bus.dm_addr, 32'h100);
        tick();
        dm_bus.dm_ack = 1'b1;
        mid();
        chk("sh_hold_be", {28'd0, dm_bus.dm_be}, 32'hC);
        chk("sh_hold_req", {31'd0, dm_bus.dm_req}, 32'd1);
        tick();
        dm_bus.dm_ack = 1'b0;
        mid();
        chk("sh_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("sh_done_stall", {31'd0, stall}, 32'd0);
        tick();

        // LW 0x202 misaligned
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h202, 32'd0, 5'd3);
        mid();
        chk("lw_mis_stall_n", {31'd0, stall}, 32'd0);
        tick();
        idle_in();
        mid();
        chk("lw_mis_pulse", {31'd0, exc_misalign}, 32'd1);
        chk("lw_mis_req", {31'd0, dm_bus.dm_req}, 32'd0);
        chk("lw_mis_stall", {31'd0, stall}, 32'd0);
        tick();
        mid();
        chk("lw_mis_end", {31'd0, exc_misalign}, 32'd0);
        chk("lw_mis_req2", {31'd0, dm_bus.dm_req}, 32'd0);
        tick();

        // LHU 0x002, ack withheld: 4 REQ cycles then bus error
        drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h002, 32'd0, 5'd7);
        tick();
        idle_in();
        for (int i = 0; i < 4; i++) begin
            mid();
            chk($sformatf("to_req_%0d", i), {31'd0, dm_bus.dm_req}, 32'd1);
            chk($sformatf("to_nobus_%0d", i), {31'd0, exc_buserr}, 32'd0);
            tick();
        end
        mid();
        chk("to_req_drop", {31'd0, dm_bus.dm_req}, 32'd0);
        chk("to_buserr", {31'd0, exc_buserr}, 32'd1);
        chk("to_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd0);
        tick();
        mid();
        chk("to_buserr_end", {31'd0, exc_buserr}, 32'd0);
        tick();

        // LH 0x002, ack in the last counted cycle counts as success
        drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h002, 32'd0, 5'd9);
        tick();
        idle_in();
        tick();
        tick();
        tick();
        dm_bus.dm_rdata = 32'h8001_0000;
        dm_bus.dm_ack   = 1'b1;
        mid();
        chk("edge_req", {31'd0, dm_bus.dm_req}, 32'd1);
        tick();
        dm_bus.dm_ack = 1'b0;
        mid();
        chk("edge_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("edge_wb_data", wb_data, 32'hFFFF_8001);
        chk("edge_no_buserr", {31'd0, exc_buserr}, 32'd0);
        tick();

        // No-op requests: both ops, then illegal memType
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h400, 32'd0, 5'd1);
        mid();
        chk("nop_both_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h400, 32'd0, 5'd1);
        mid();
        chk("nop_both_req", {31'd0, dm_bus.dm_req}, 32'd0);
        chk("nop_mt_stall", {31'd0, stall}, 32'd0);
        tick();
        idle_in();
        mid();
        chk("nop_mt_req", {31'd0, dm_bus.dm_req}, 32'd0);
        chk("nop_mt_exc", {31'd0, exc_misalign}, 32'd0);
        tick();

        // LBU 0x001 to x0
        drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h001, 32'd0, 5'd0);
        tick();
        idle_in();
        dm_bus.dm_rdata = 32'h0000_8000;
        dm_bus.dm_ack   = 1'b1;
        tick();
        dm_bus.dm_ack = 1'b0;
        mid();
        chk("lbu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("lbu_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("lbu_wb_data", wb_data, 32'h0000_0080);
        tick();

        // SB 0x102
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h102, 32'h1234_5678, 5'd0);
        tick();
        idle_in();
        dm_bus.dm_ack = 1'b1;
        mid();
        chk("sb_be", {28'd0, dm_bus.dm_be}, 32'h4);
        chk("sb_wdata", dm_bus.dm_wdata, 32'h7878_7878);
        tick();
        dm_bus.dm_ack = 1'b0;
        mid();
        chk("sb_no_wb", {31'd0, wb_valid}, 32'd0);
        tick();

        // Ack while idle is ignored
        dm_bus.dm_ack = 1'b1;
        tick();
        dm_bus.dm_ack = 1'b0;
        mid();
        chk("idle_ack_wb", {31'd0, wb_valid}, 32'd0);
        tick();

        // Reset in 2nd REQ cycle, ack one cycle later
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd4);
        tick();
        idle_in();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dm_bus.dm_ack = 1'b1;
        mid();
        chk("rreq_req", {31'd0, dm_bus.dm_req}, 32'd0);
        chk("rreq_stall", {31'd0, stall}, 32'd0);
        chk("rreq_outs", {28'd0, wb_valid, exc_misalign, exc_buserr,
                          dm_bus.dm_we}, 32'd0);
        tick();
        dm_bus.dm_ack = 1'b0;
        mid();
        chk("rreq_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("rreq_idle_req", {31'd0, dm_bus.dm_req}, 32'd0);
        chk("rreq_idle_stall", {31'd0, stall}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the number of REQ-state cycles without dm_ack before a bus error is declared (legal range 1..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ex_valid  input  1  EX/MEM slot holds a live instruction.
REQ-005 ex_memRead  input  1  load request.
REQ-006 ex_memWrite  input  1  store request.
REQ-007 ex_memType  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ex_addr  input  32  byte address (execute result).
REQ-009 ex_wdata  input  32  store source (rs2 data).
REQ-010 ex_rd  input  5  load destination register.
REQ-011 stall  output  1  holds upstream pipeline registers.
REQ-012 dm_req, dm_we  output  1 each  memory request / write enable.
REQ-013 dm_addr  output  32  word-aligned address; bits [1:0] SHALL be 0.
REQ-014 dm_be  output  4  byte enables; dm_wdata  output  32  lane-replicated store data.
REQ-015 dm_rdata  input  32  read word; dm_ack  input  1  completion, valid only while dm_req=1.
REQ-016 wb_valid  output  1  single-cycle pulse; wb_rd  output  5; wb_data  output  32  extended load result.
REQ-017 exc_misalign, exc_buserr  output  1 each  single-cycle exception pulses.

Function
REQ-018 FSM states SHALL be IDLE, REQ and DONE.
REQ-019 Accept in IDLE when ex_valid=1 and exactly one of memRead/memWrite is set, memType is legal and the address is aligned; next state is REQ.
REQ-020 ex_valid with both or neither of memRead/memWrite set, or with memType 011/110/111, SHALL be a no-op: no request, no pulse, no stall.
REQ-021 Misaligned access (H/HU with addr[0]=1; W with addr[1:0]!=0) SHALL pulse exc_misalign in the next cycle, issue no request and not stall.
REQ-022 stall SHALL be combinationally high in the accept cycle and in every REQ cycle; it SHALL be low in DONE and in IDLE when not accepting.
REQ-023 In REQ, dm_req=1 with all dm_* outputs registered at accept and held stable until dm_ack or timeout.
REQ-024 Store byte enables: SB = 0001 shifted left by addr[1:0], byte replicated x4; SH = 0011 (addr[1]=0) or 1100, halfword replicated x2; SW = 1111.
REQ-025 Loads SHALL drive dm_we=0 and dm_be=1111.
REQ-026 On dm_ack in REQ: go to DONE; for loads, capture the extracted lane from dm_rdata, sign-extended (B/H) or zero-extended (BU/HU); W passes through.
REQ-027 DONE lasts exactly one cycle, then IDLE; loads pulse wb_valid with wb_rd/wb_data in DONE; stores never assert wb_valid.
REQ-028 Minimum latency: accept cycle N, dm_req N+1, dm_ack N+1, wb_valid and stall=0 at N+2.
REQ-029 Wait counter SHALL clear on accept and increment each REQ cycle without dm_ack; at TIMEOUT it SHALL drop dm_req, go to DONE, pulse exc_buserr and suppress wb_valid.
REQ-030 dm_ack outside REQ SHALL be ignored; dm_ack in the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-031 Load with ex_rd=0 SHALL still access memory and pulse wb_valid with wb_rd=0.

Reset
REQ-032 rst=1 SHALL force IDLE, counter 0, and all outputs 0 (including stall, dm_req, wb_*, exc_*) at the next edge.
REQ-033 Reset during REQ SHALL abandon the access; a later dm_ack SHALL produce no wb_valid.

Structure
REQ-034 Package mem_pkg SHALL hold the memType encodings, the FSM state enum and the TIMEOUT default.
REQ-035 Lane extraction and extension SHALL be the combinational sub-module load_aligner (inputs rdata, addr[1:0], memType; output 32-bit result).

Verification
REQ-036 LB addr 0x103, dm_rdata 0x80FF_FF12, ack in first REQ cycle -> wb_data 0xFFFF_FF80, wb_valid at N+2.
REQ-037 SH addr 0x102, wdata 0x0000_BEEF -> dm_be 1100, dm_wdata 0xBEEF_BEEF, dm_addr 0x100, no wb_valid.
REQ-038 LW addr 0x202 -> exc_misalign pulse at N+1, dm_req never rises, stall high only in cycle N... no: stall stays low; bench checks stall=0 throughout.
REQ-039 LHU addr 0x002, dm_ack withheld, TIMEOUT=4 -> dm_req high 4 cycles, exc_buserr one pulse, no wb_valid.
REQ-040 rst asserted in the 2nd REQ cycle, dm_ack one cycle later -> all outputs 0, no wb_valid, FSM in IDLE.
